// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the RISC-V datapath blocks.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_VECTOR     = 32'h0000_0000;
    localparam int          INSTR_ALIGN_BITS = 2;

endpackage : riscv_pkg

// File: rtl/registro_pc.sv
// Program-counter register: loads the next PC when enabled, resets
// asynchronously to the boot vector, and flags misaligned PC values.
module registro_pc
    import riscv_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VECTOR),
    parameter int               ALIGN_BITS  = INSTR_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] entrada,
    input  logic             en,
    output logic [WIDTH-1:0] salida,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_r;

    // PC flop bank: reset to boot vector, load on en, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_VALUE;
        end else if (en) begin
            pc_r <= entrada;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign salida = pc_r;

    // Status only; a misaligned PC is still stored verbatim.
    assign misaligned = |pc_r[ALIGN_BITS-1:0];

endmodule : registro_pc

// File: tb/tb_registro_pc.sv
// Self-checking bench for registro_pc: directed vector table, hand-written
// reset sequences and randomized traffic against a reference model.
module tb_registro_pc;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] entrada;
    logic [31:0] salida;
    logic        misaligned;
    logic [31:0] salida_b;
    logic        misaligned_b;

    int n_cmp;
    int n_bad;

    localparam logic [31:0] RV_B = 32'h8000_0000;

    registro_pc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entrada    (entrada),
        .en         (en),
        .salida     (salida),
        .misaligned (misaligned)
    );

    registro_pc #(.RESET_VALUE(RV_B)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .entrada    (entrada),
        .en         (en),
        .salida     (salida_b),
        .misaligned (misaligned_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] d;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [12];

    // Reference model state: the PC each instance should hold.
    logic [31:0] mdl_a;
    logic [31:0] mdl_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mis_of(input logic [31:0] v);
        return (v % 32'd4) != 32'd0;
    endfunction

    task automatic check_both(input string tag);
        chk({tag, " salida"},       salida,                 mdl_a);
        chk({tag, " misaligned"},   {31'd0, misaligned},    {31'd0, mis_of(mdl_a)});
        chk({tag, " salida_b"},     salida_b,               mdl_b);
        chk({tag, " misaligned_b"}, {31'd0, misaligned_b},  {31'd0, mis_of(mdl_b)});
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic cycle(input logic e, input logic [31:0] d);
        en      = e;
        entrada = d;
        @(posedge clk);
        @(negedge clk);
        if (rst_n && e) begin
            mdl_a = d;
            mdl_b = d;
        end
    endtask

    // Pulse reset 3 ns after a rising edge, holding it across one rising edge.
    task automatic mid_reset(input logic [31:0] d);
        en      = 1'b1;
        entrada = d;
        @(posedge clk);
        mdl_a = d;
        mdl_b = d;
        #3;
        rst_n = 1'b0;
        mdl_a = 32'h0000_0000;
        mdl_b = RV_B;
        #1;
        check_both("midrst_immediate");
        @(posedge clk);
        #1;
        check_both("midrst_held");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        entrada = 32'h0000_1234;
        mdl_a   = 32'h0000_0000;
        mdl_b   = RV_B;

        tbl[0]  = '{1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1};
        tbl[1]  = '{1'b1, 32'h0000_000A, 32'h0000_000A, 1'b1};
        tbl[2]  = '{1'b1, 32'h0000_000F, 32'h0000_000F, 1'b1};
        tbl[3]  = '{1'b1, 32'h0000_0004, 32'h0000_0004, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0200, 32'h0000_0200, 1'b0};
        tbl[9]  = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_0002, 32'h0000_0002, 1'b1};

        // Reset held across several rising edges with a load pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset salida",       salida,              32'h0000_0000);
            chk("reset misaligned",   {31'd0, misaligned}, 32'd0);
            chk("reset salida_b",     salida_b,            RV_B);
        end
        rst_n = 1'b1;
        cycle(1'b1, 32'h0000_1234);
        chk("release load", salida, 32'h0000_1234);
        chk("release load_b", salida_b, 32'h0000_1234);
        chk("release misaligned", {31'd0, misaligned}, 32'd0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].en, tbl[i].d);
            chk($sformatf("vec%0d salida", i),     salida,              tbl[i].exp_pc);
            chk($sformatf("vec%0d misaligned", i), {31'd0, misaligned}, {31'd0, tbl[i].exp_mis});
        end

        // Asynchronous reset in the middle of operation after loading 0x40.
        cycle(1'b1, 32'h0000_0040);
        chk("pre-midrst salida", salida, 32'h0000_0040);
        mid_reset(32'h0000_0077);
        cycle(1'b1, 32'h0000_0088);
        check_both("post-midrst load");

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                mid_reset($urandom);
            end else begin
                cycle(($urandom_range(0, 3) != 0), $urandom);
            end
            check_both("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_registro_pc
